mips_data_mem_arbiter: RTL

// Shares one single-port synchronous data RAM between the harvard CPU data port and a

---
 rtl/mips_data_mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mips_data_mem_arbiter.sv
// mips_data_mem_arbiter: round-robin sharing of one synchronous data RAM between the CPU data port and a loader
module mips_data_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_address,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [31:0]       data_writedata,
  output logic [31:0]       data_readdata,
  output logic              clk_enable,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, CPU_WAIT, CPU_DONE, LD_WAIT} state_t;
  state_t        state;
  logic          last_ld;
  logic [CW-1:0] count;
  logic          cpu_pend, cpu_in_range, in_idle, grant_cpu, grant_ld;
  logic          unused_ok;
  assign unused_ok    = &{1'b0, data_address[1:0]};
  assign cpu_pend     = data_read | data_write;
  assign cpu_in_range = data_address[31:ADDR_W+2] == '0;
  assign in_idle      = reset && state == IDLE;
  assign grant_cpu    = in_idle && cpu_pend && (!ld_valid || last_ld);
  assign grant_ld     = in_idle && ld_valid && !grant_cpu;
  assign clk_enable   = !cpu_pend || state == CPU_DONE;
  assign ld_ready     = grant_ld;
  assign mem_req      = (grant_cpu && cpu_in_range) || grant_ld;
  assign mem_we       = mem_req && (grant_cpu ? data_write : ld_we);
  assign mem_addr     = grant_cpu ? data_address[ADDR_W+1:2] : ld_addr;
  assign mem_wdata    = grant_cpu ? data_writedata : ld_wdata;
  // arbitration FSM: one RAM access in flight, read data captured after LATENCY cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_ld       <= 1'b1;
      count         <= '0;
      data_readdata <= '0;
      ld_rdata      <= '0;
      ld_rvalid     <= 1'b0;
    end else begin
      ld_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            last_ld <= 1'b0;
            if (!cpu_in_range) begin
              if (!data_write) data_readdata <= '0;
              state <= CPU_DONE;
            end else if (data_write) begin
              state <= CPU_DONE;
            end else begin
              count <= CW'(LATENCY - 1);
              state <= CPU_WAIT;
            end
          end else if (grant_ld) begin
            last_ld <= 1'b1;
            if (!ld_we) begin
              count <= CW'(LATENCY - 1);
              state <= LD_WAIT;
            end
          end
        end
        CPU_WAIT: begin
          if (count == '0) begin
            data_readdata <= mem_rdata;
            state         <= CPU_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        CPU_DONE: state <= IDLE;
        LD_WAIT: begin
          if (count == '0) begin
            ld_rdata  <= mem_rdata;
            ld_rvalid <= 1'b1;
            state     <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
